// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 8-input mux round-robin arbiter.
package mux_arb_pkg;

  localparam int N_IN   = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;  // holds MAX_HOLD up to 15
  localparam int GAP_W  = 3;  // holds GAP_CYCLES up to 7

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // One-hot decode of a mux select index.
  function automatic logic [N_IN-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    return {{(N_IN-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: the first set REQ bit after LAST, wrapping mod 8.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_IN-1:0]  REQ,
  input  logic [SEL_W-1:0] LAST,
  output logic [SEL_W-1:0] IDX,
  output logic             ANY
);

  logic [SEL_W-1:0]  start;
  logic [2*N_IN-1:0] dbl;
  logic [N_IN-1:0]   rot;
  logic [SEL_W-1:0]  enc;

  // Rotate so bit 0 is the highest-priority requester (LAST+1, wrapping).
  assign start = LAST + 3'd1;
  assign dbl   = {REQ, REQ};
  assign rot   = dbl[start +: N_IN];
  assign ANY   = |REQ;

  // Priority-encode the lowest set bit of the rotated vector, then un-rotate.
  always_comb begin
    // NOTE: enc gets a value before the loop so that no path leaves it unassigned, which would infer a latch.
    enc = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (rot[i]) enc = SEL_W'(i);
    end
    IDX = start + enc;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin sequencer sharing one 8:1 mux among eight requesters, with
// bounded grant hold, break-before-make gaps and a registered data sample.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_IN-1:0]  REQ,
  input  logic             MUX_OUT,
  output logic [N_IN-1:0]  GNT,
  output logic [SEL_W-1:0] S,
  output logic             EN_BAR,
  output logic             DOUT,
  output logic             DOUT_VALID
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [GAP_W-1:0]  GAP_C      = GAP_W'(GAP_CYCLES);

  arb_state_t        state, state_nxt;
  logic [SEL_W-1:0]  last, last_nxt, s_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick8 u_pick (
    .REQ  (REQ),
    .LAST (last),
    .IDX  (pick_idx),
    .ANY  (pick_any)
  );

  // Next-state logic: arbitrate from IDLE or at the end of the gap, bound each grant.
  always_comb begin
    state_nxt = state;
    s_nxt     = S;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          s_nxt     = pick_idx;
          last_nxt  = pick_idx;
          hold_nxt  = 4'd1;
        end
      end
      GRANT: begin
        if (!REQ[S] || hold_cnt == MAX_HOLD_C) begin
          state_nxt = GAP;
          gap_nxt   = GAP_C;
        end else begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      GAP: begin
        if (gap_cnt <= 3'd1) begin
          if (pick_any) begin
            // Previous winner sits at LAST, so it is last in the scan order.
            state_nxt = GRANT;
            s_nxt     = pick_idx;
            last_nxt  = pick_idx;
            hold_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap_cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; mux controls are decoded from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      S        <= '0;
      last     <= 3'd7;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      GNT      <= '0;
      EN_BAR   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      S        <= s_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      GNT      <= (state_nxt == GRANT) ? sel_onehot(s_nxt) : '0;
      EN_BAR   <= (state_nxt != GRANT);
    end
  end

  // Sample the mux output on every grant cycle; DOUT holds otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT       <= 1'b0;
      DOUT_VALID <= 1'b0;
    end else if (state == GRANT) begin
      DOUT       <= MUX_OUT;
      DOUT_VALID <= 1'b1;
    end else begin
      DOUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with a behavioural 8:1 mux in the loop.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mux_out;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       en_bar;
  logic       dout;
  logic       dout_valid;

  logic [7:0] mux_in = 8'b1010_1011;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Stand-in for mux8_to_1: output low while disabled.
  assign mux_out = en_bar ? 1'b0 : mux_in[s];

  mux8_rr_arbiter dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ        (req),
    .MUX_OUT    (mux_out),
    .GNT        (gnt),
    .S          (s),
    .EN_BAR     (en_bar),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"}, gnt, 8'h00);
    check({tag, " en_bar"}, {7'd0, en_bar}, 8'd1);
  endtask

  // n grant cycles to input idx; the first edge is the one that samples the request.
  task automatic grant_seq(input int idx, input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("grant%0d_%0d gnt", idx, k), gnt, 8'h01 << idx);
      check($sformatf("grant%0d_%0d s", idx, k), {5'd0, s}, 8'(idx));
      check($sformatf("grant%0d_%0d en_bar", idx, k), {7'd0, en_bar}, 8'd0);
      check($sformatf("grant%0d_%0d dv", idx, k), {7'd0, dout_valid}, (k > 1) ? 8'd1 : 8'd0);
      if (k > 1)
        check($sformatf("grant%0d_%0d dout", idx, k), {7'd0, dout}, {7'd0, mux_in[idx]});
    end
  endtask

  // The single gap cycle after a grant to idx; DOUT still shows the last grant sample.
  task automatic gap_seq(input int idx);
    tick();
    check($sformatf("gap%0d gnt", idx), gnt, 8'h00);
    check($sformatf("gap%0d en_bar", idx), {7'd0, en_bar}, 8'd1);
    check($sformatf("gap%0d s", idx), {5'd0, s}, 8'(idx));
    check($sformatf("gap%0d dv", idx), {7'd0, dout_valid}, 8'd1);
    check($sformatf("gap%0d dout", idx), {7'd0, dout}, {7'd0, mux_in[idx]});
  endtask

  initial begin
    // Reset held with every input requesting.
    rst = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset");
      check("reset s", {5'd0, s}, 8'd0);
      check("reset dv", {7'd0, dout_valid}, 8'd0);
      check("reset dout", {7'd0, dout}, 8'd0);
    end
    req = 8'h00;
    rst = 1'b0;
    tick();
    check_idle("idle");

    // All requesting: 0..7 then back to 0, four cycles each with one gap.
    req = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      grant_seq(i, 4);
      gap_seq(i);
    end
    grant_seq(0, 4);
    req = 8'h00;
    gap_seq(0);
    tick();
    check_idle("all_end");
    check("all_end dv", {7'd0, dout_valid}, 8'd0);

    // Single held request is re-granted after one gap cycle.
    req = 8'h04;
    grant_seq(2, 4);
    gap_seq(2);
    grant_seq(2, 4);
    req = 8'h00;
    gap_seq(2);
    tick();
    check_idle("single_end");

    // Early release after two sampling edges.
    req = 8'h20;
    grant_seq(5, 2);
    req = 8'h00;
    gap_seq(5);
    tick();
    check_idle("release_end");
    check("release_end dout held", {7'd0, dout}, 8'd1);

    // Rotation from LAST=5 with inputs 0 and 4 requesting.
    req = 8'h11;
    grant_seq(0, 4);
    gap_seq(0);
    grant_seq(4, 4);
    gap_seq(4);
    grant_seq(0, 4);
    req = 8'h00;
    gap_seq(0);
    tick();
    check_idle("rot_end");

    // Asynchronous reset between edges during a grant to input 3.
    req = 8'h08;
    grant_seq(3, 2);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async");
    check("async s", {5'd0, s}, 8'd0);
    check("async dv", {7'd0, dout_valid}, 8'd0);
    check("async dout", {7'd0, dout}, 8'd0);
    req = 8'hFF;
    tick();
    check_idle("async_hold");
    rst = 1'b0;
    grant_seq(0, 4);
    req = 8'h00;
    gap_seq(0);
    tick();
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the 8-to-1 multiplexer (`mux8_to_1`). It shares the mux between eight requesters, drives the mux select `S` and active-low enable `EN_BAR`, and registers the selected mux output. Grants are break-before-make, and the hold time of each grant is bounded. At integration it sits beside `mux8_to_1`: `S`/`EN_BAR` go to the mux, and the mux `OUTPUT` returns on `MUX_OUT`.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per requester, range 1..15.
- `GAP_CYCLES`, default 1: cycles with `EN_BAR`=1 between grants, range 1..7.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `REQ` input 8: request per mux input; bit i asks for mux input i.
- `MUX_OUT` input 1: combinational output of the mux.
- `GNT` output 8: one-hot grant, registered.
- `S` output 3: mux select, registered.
- `EN_BAR` output 1: mux enable, active low, registered.
- `DOUT` output 1: registered sample of `MUX_OUT`.
- `DOUT_VALID` output 1: `DOUT` was captured during a grant cycle.

## Operation
- Reset values: `GNT`=0, `S`=0, `EN_BAR`=1, `DOUT`=0, `DOUT_VALID`=0, state IDLE, `LAST`=7 so the first search starts at input 0, hold counter 0.
- States:
  - IDLE: `EN_BAR`=1, `GNT`=0. At an edge with `REQ`≠0, pick the winner and go to GRANT.
  - GRANT: `GNT`=1<<`S`, `EN_BAR`=0.
  - GAP: `EN_BAR`=1, `GNT`=0, `S` holds its value.
- Winner selection: the first set bit of `REQ` scanning `LAST`+1, `LAST`+2, … mod 8. On each grant, `S`, `GNT` and `LAST` load the winner index.
- GRANT exit: at an edge where `REQ[S]`=0 or the hold counter equals `MAX_HOLD`, go to GAP and reload the gap counter.
- GAP exit: at the edge ending the `GAP_CYCLES`-th gap cycle:
  - if `REQ`≠0, re-arbitrate and go straight to GRANT;
  - otherwise go to IDLE.
  - The previous winner is eligible again, at lowest priority.
- Hold counter: 4-bit. It is 1 in the first grant cycle and increments each grant cycle. Saturation is unreachable because of the exit rule.
- Data capture: at every edge where the state is GRANT, `DOUT`<=`MUX_OUT` and `DOUT_VALID`<=1. At all other edges, `DOUT_VALID`<=0 and `DOUT` holds.
- A requester that drops `REQ` while not granted is simply skipped. `REQ` changes during GAP are seen only at the exit edge.

## Timing
- Request to grant: `REQ` sampled at edge k in IDLE gives `GNT`/`S`/`EN_BAR`=0 valid after edge k.
- Grant length with `REQ` held: exactly `MAX_HOLD` cycles. With release: grant cycles = number of edges with `REQ[S]`=1 sampled, plus 1.
- Back-to-back requesters: `MAX_HOLD` grant cycles, then `GAP_CYCLES` cycles with `EN_BAR`=1, then the next grant. `S` never changes while `EN_BAR`=0.
- `DOUT` latency: 1 cycle after the grant cycle it samples. `DOUT_VALID` is high for exactly as many cycles as the grant lasted, shifted by one.
- Reset mid-operation: `RST` forces all outputs to their reset values immediately, independent of `CLK`. The first grant after release restarts the search at input 0.

## Structure
- Package `mux_arb_pkg`:
  - `N_IN`=8, `SEL_W`=3;
  - state enum {IDLE, GRANT, GAP};
  - counter width constants.
- Sub-module `rr_pick8`: combinational. Inputs are `REQ[7:0]` and `LAST[2:0]`; outputs are `IDX[2:0]` and `ANY`. It rotates, priority-encodes, then un-rotates.
- `mux8_to_1` is not instantiated inside. The bench instantiates both blocks and ties `MUX_OUT` to the mux output.

## Test plan
Default parameters (`MAX_HOLD`=4, `GAP_CYCLES`=1); mux `IN`=8'b1010_1011.
- Reset: hold `RST`=1 for 3 cycles with `REQ`=8'hFF -> `GNT`=0, `S`=0, `EN_BAR`=1, `DOUT_VALID`=0 throughout.
- Single held request: `REQ`=8'h04 -> `GNT`=8'h04 and `S`=2 for 4 cycles, 1 gap cycle, then re-granted. `DOUT`=0 with `DOUT_VALID` high for 4 cycles per grant.
- All requesting: `REQ`=8'hFF -> grants go to inputs 0,1,…,7,0, each 4 cycles plus 1 gap. `DOUT` per grant reads 1,1,0,1,0,1,0,1.
- Early release: `REQ`=8'h20 for 2 edges, then 0 -> 2 grant cycles with `S`=5 and `DOUT`=1, 1 gap cycle, then IDLE.
- Rotation: after a grant to input 5, `REQ`=8'h11 -> next grant is input 0, then input 4, then input 0.
- Async reset mid-grant: assert `RST` between edges during a grant to input 3 -> `EN_BAR`=1 and `GNT`=0 immediately. After release, `REQ`=8'hFF gives the first grant to input 0.
